// File: rtl/uart_wb_bridge_pkg.sv
// uart_wb_bridge_pkg
//   Shared types and constants for the UART-to-Wishbone debug bridge.
//   - state_t   : bridge FSM states
//   - CMD_*     : command bytes recognised on the receive stream
//   - RSP_*     : single-byte status responses sent on the transmit stream
//   - rsp_word  : left-justifies a one-byte response into the serializer word
package uart_wb_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WB,
        RESP
    } state_t;

    localparam logic [7:0] CMD_WRITE   = 8'h57;  // 'W'
    localparam logic [7:0] CMD_READ    = 8'h52;  // 'R'

    localparam logic [7:0] RSP_OK      = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR     = 8'h45;  // 'E'
    localparam logic [7:0] RSP_TIMEOUT = 8'h54;  // 'T'

    // The serializer always sends from the top byte down, so a single-byte
    // response sits in the MSB lane.
    function automatic logic [31:0] rsp_word(input logic [7:0] b);
        return {b, 24'h000000};
    endfunction

endpackage

// File: rtl/uart_wb_bridge_resp.sv
// uart_wb_bridge_resp
//   Response serializer: loads a 32-bit word plus a byte count (1 or 4) and
//   sends it MSB first on a valid/ready byte stream.
//   Ports:
//     clk, srst      : clock, synchronous active-high reset
//     load           : capture load_word/load_len this cycle
//     load_word      : response bytes, first byte in [31:24]
//     load_len       : number of bytes to send (1..4)
//     tx_ready       : downstream accepts tx_byte this cycle
//     tx_byte        : current byte (held stable until accepted)
//     tx_valid       : tx_byte valid
//     last           : the final byte is being accepted this cycle
module uart_wb_bridge_resp (
    input  logic        clk,
    input  logic        srst,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic [2:0]  load_len,
    input  logic        tx_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    output logic        last
);

    logic [31:0] shift_reg;
    logic [2:0]  remaining_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            shift_reg     <= '0;
            remaining_reg <= '0;
        end else if (load) begin
            shift_reg     <= load_word;
            remaining_reg <= load_len;
        end else if (tx_valid && tx_ready) begin
            // Zeros shift in behind, so tx_byte reads 0 once the stream ends.
            shift_reg     <= {shift_reg[23:0], 8'h00};
            remaining_reg <= remaining_reg - 3'd1;
        end
    end

    assign tx_valid = (remaining_reg != 3'd0);
    assign tx_byte  = shift_reg[31:24];
    assign last     = tx_valid && tx_ready && (remaining_reg == 3'd1);

endmodule

// File: rtl/uart_wb_bridge.sv
// uart_wb_bridge
//   Parses 'W'/'R' command packets from a UART receive byte stream, runs one
//   32-bit Wishbone master cycle per packet and returns the result on the
//   UART transmit byte stream.
//     Write: 57 A3 A2 A1 A0 D3 D2 D1 D0  -> 4B (ack) / 45 (err)
//     Read : 52 A3 A2 A1 A0              -> D3 D2 D1 D0 (ack) / 45 (err)
//   Ports:
//     i_clk, i_rst               : clock, synchronous active-high reset
//     i_rx_byte/valid, o_rx_ready: receive byte stream (from UART)
//     o_tx_byte/valid, i_tx_ready: transmit byte stream (to UART)
//     o_wb_*, i_wb_*             : Wishbone master (single cycles, sel all ones)
//     o_busy                     : high whenever the FSM is not in IDLE
//   Build option:
//     UART_WB_BRIDGE_TIMEOUT_EN  : abort a Wishbone cycle after TIMEOUT_CYCLES
//                                  without ack/err and respond 'T'.
module uart_wb_bridge
    import uart_wb_bridge_pkg::*;
#(
    parameter int WB_DWIDTH      = 32,
    parameter int WB_SWIDTH      = WB_DWIDTH / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [7:0]           i_rx_byte,
    input  logic                 i_rx_valid,
    output logic                 o_rx_ready,
    output logic [7:0]           o_tx_byte,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic [31:0]          o_wb_adr,
    output logic [WB_SWIDTH-1:0] o_wb_sel,
    output logic                 o_wb_we,
    output logic [WB_DWIDTH-1:0] o_wb_dat,
    input  logic [WB_DWIDTH-1:0] i_wb_dat,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    input  logic                 i_wb_ack,
    input  logic                 i_wb_err,
    output logic                 o_busy
);

    state_t      state_reg;
    logic [1:0]  cnt_reg;
    logic        we_reg;
    logic        cyc_reg;
    logic        rx_ready_reg;
    logic        busy_reg;
    logic [31:0] adr_reg;
    logic [31:0] dat_reg;

    logic        rx_fire;
    logic        wb_term;
    logic        timeout_hit;
    logic        resp_load;
    logic        resp_last;
    logic [31:0] resp_word;
    logic [2:0]  resp_len;

    assign rx_fire = i_rx_valid && rx_ready_reg;

    // Ack/err only count while a cycle is actually outstanding.
    assign wb_term = (state_reg == WB) && (i_wb_ack || i_wb_err);

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMO_W-1:0] tmo_cnt_reg;

    // Held at zero outside WB, so it always starts from 0 on entry.
    always_ff @(posedge i_clk) begin
        if (i_rst || (state_reg != WB)) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
        end
    end

    // A real ack/err on the same cycle takes priority over the timeout.
    assign timeout_hit = (state_reg == WB) && !wb_term &&
                         (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign resp_load = wb_term || timeout_hit;

    // Response selection; only consumed on the cycle resp_load is high.
    // Read data is taken straight from the bus on the ack cycle.
    always_comb begin
        resp_word = rsp_word(RSP_TIMEOUT);
        resp_len  = 3'd1;
        if (i_wb_err) begin
            resp_word = rsp_word(RSP_ERR);
        end else if (i_wb_ack) begin
            if (we_reg) begin
                resp_word = rsp_word(RSP_OK);
            end else begin
                resp_word = i_wb_dat[31:0];
                resp_len  = 3'd4;
            end
        end
    end

    uart_wb_bridge_resp u_resp (
        .clk       (i_clk),
        .srst      (i_rst),
        .load      (resp_load),
        .load_word (resp_word),
        .load_len  (resp_len),
        .tx_ready  (i_tx_ready),
        .tx_byte   (o_tx_byte),
        .tx_valid  (o_tx_valid),
        .last      (resp_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 2'd0;
            we_reg       <= 1'b0;
            cyc_reg      <= 1'b0;
            rx_ready_reg <= 1'b0;
            busy_reg     <= 1'b0;
            adr_reg      <= '0;
            dat_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    rx_ready_reg <= 1'b1;
                    // Non-command bytes are accepted and silently dropped.
                    if (rx_fire && ((i_rx_byte == CMD_WRITE) || (i_rx_byte == CMD_READ))) begin
                        we_reg    <= (i_rx_byte == CMD_WRITE);
                        cnt_reg   <= 2'd0;
                        busy_reg  <= 1'b1;
                        state_reg <= ADDR;
                    end
                end
                ADDR: begin
                    if (rx_fire) begin
                        adr_reg <= {adr_reg[23:0], i_rx_byte};
                        cnt_reg <= cnt_reg + 2'd1;  // wraps to 0 after the 4th byte
                        if (cnt_reg == 2'd3) begin
                            if (we_reg) begin
                                state_reg <= DATA;
                            end else begin
                                state_reg    <= WB;
                                cyc_reg      <= 1'b1;
                                rx_ready_reg <= 1'b0;
                            end
                        end
                    end
                end
                DATA: begin
                    if (rx_fire) begin
                        dat_reg <= {dat_reg[23:0], i_rx_byte};
                        cnt_reg <= cnt_reg + 2'd1;
                        if (cnt_reg == 2'd3) begin
                            state_reg    <= WB;
                            cyc_reg      <= 1'b1;
                            rx_ready_reg <= 1'b0;
                        end
                    end
                end
                WB: begin
                    if (resp_load) begin
                        cyc_reg   <= 1'b0;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (resp_last) begin
                        state_reg    <= IDLE;
                        busy_reg     <= 1'b0;
                        rx_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Byte selects mirror cyc: all ones during a cycle, zero otherwise.
    for (genvar gi = 0; gi < WB_SWIDTH; gi++) begin : g_sel
        assign o_wb_sel[gi] = cyc_reg;
    end

    assign o_rx_ready = rx_ready_reg;
    assign o_busy     = busy_reg;
    assign o_wb_cyc   = cyc_reg;
    assign o_wb_stb   = cyc_reg;
    assign o_wb_we    = we_reg && cyc_reg;
    assign o_wb_adr   = adr_reg;
    assign o_wb_dat   = WB_DWIDTH'(dat_reg);

endmodule

// File: tb/tb_uart_wb_bridge.sv
// tb_uart_wb_bridge
//   Table-driven bench for uart_wb_bridge. Each vector describes one packet
//   plus the Wishbone slave's reply; expected transmit bytes go into a queue
//   when the reply is driven and are popped as the bridge sends them.
//   Hand-written sequences cover reset mid-cycle, stray ack/err in IDLE and,
//   when UART_WB_BRIDGE_TIMEOUT_EN is defined, the 16-cycle timeout.
module tb_uart_wb_bridge;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_rx_byte = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready;
    logic [7:0]  o_tx_byte;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b0;
    logic [31:0] o_wb_adr;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic [31:0] o_wb_dat;
    logic [31:0] i_wb_dat = 32'h0;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        i_wb_ack = 1'b0;
    logic        i_wb_err = 1'b0;
    logic        o_busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_wb_bridge #(
        .WB_DWIDTH      (32),
        .WB_SWIDTH      (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_rx_byte  (i_rx_byte),
        .i_rx_valid (i_rx_valid),
        .o_rx_ready (o_rx_ready),
        .o_tx_byte  (o_tx_byte),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_wb_adr   (o_wb_adr),
        .o_wb_sel   (o_wb_sel),
        .o_wb_we    (o_wb_we),
        .o_wb_dat   (o_wb_dat),
        .i_wb_dat   (i_wb_dat),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .i_wb_ack   (i_wb_ack),
        .i_wb_err   (i_wb_err),
        .o_busy     (o_busy)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        int          dly;       // cycles of cyc before the reply
        logic        ack;
        logic        err;
        logic [31:0] rdat;
        int          nresp;     // expected response byte count
        logic [31:0] resp;      // expected bytes, first in [31:24]
        int          stall_at;  // tx byte index to stall before, -1 = none
        logic        garbage;   // prefix packet with 00 FF
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int g = 0;
        i_rx_byte  = b;
        i_rx_valid = 1'b1;
        while (!o_rx_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!o_rx_ready) check("rx_ready_wait", 32'(o_rx_ready), 32'd1);
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic drain(input int stall_at, input int stall_len);
        int sent = 0;
        int stalled = 0;
        int guard = 0;
        logic [7:0] held = 8'h00;
        logic [7:0] want;
        while (exp_q.size() != 0 && guard < 100) begin
            i_tx_ready = !(sent == stall_at && stalled < stall_len);
            if (o_tx_valid) begin
                if (!i_tx_ready) begin
                    if (stalled == 0) held = o_tx_byte;
                    else check("tx_stable", 32'(o_tx_byte), 32'(held));
                    stalled++;
                end else begin
                    want = exp_q.pop_front();
                    check("tx_byte", 32'(o_tx_byte), 32'(want));
                    $display("  tx byte %h (expected %h)", o_tx_byte, want);
                    sent++;
                end
            end
            @(negedge clk);
            guard++;
        end
        i_tx_ready = 1'b0;
        check("tx_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic send_packet(input logic we, input logic [31:0] adr, input logic [31:0] wdat);
        send_byte(we ? 8'h57 : 8'h52);
        for (int k = 3; k >= 0; k--) send_byte(adr[8*k +: 8]);
        if (we) for (int k = 3; k >= 0; k--) send_byte(wdat[8*k +: 8]);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] w;
        $display("vec %0d: we=%0d adr=%h wdat=%h ack=%0d err=%0d rdat=%h",
                 idx, v.we, v.adr, v.wdat, v.ack, v.err, v.rdat);
        if (v.garbage) begin
            send_byte(8'h00);
            send_byte(8'hFF);
            check("garbage_dropped", 32'(o_busy), 32'd0);
        end
        send_packet(v.we, v.adr, v.wdat);
        // One edge after the last byte: cycle must already be up.
        check("cyc_latency", 32'(o_wb_cyc), 32'd1);
        check("stb",         32'(o_wb_stb), 32'd1);
        check("adr",         o_wb_adr, v.adr);
        check("we",          32'(o_wb_we), 32'(v.we));
        check("sel",         32'(o_wb_sel), 32'hF);
        check("rx_ready_wb", 32'(o_rx_ready), 32'd0);
        if (v.we) check("wdat", o_wb_dat, v.wdat);
        for (int k = 0; k < v.dly; k++) begin
            @(negedge clk);
            check("cyc_hold", 32'(o_wb_cyc), 32'd1);
        end
        i_wb_ack = v.ack;
        i_wb_err = v.err;
        i_wb_dat = v.rdat;
        w = v.resp;
        for (int k = 0; k < v.nresp; k++) begin
            exp_q.push_back(w[31:24]);
            w = w << 8;
        end
        @(negedge clk);
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        i_wb_dat = 32'h0;
        check("cyc_drop",   32'(o_wb_cyc), 32'd0);
        check("sel_drop",   32'(o_wb_sel), 32'h0);
        check("tx_valid_1", 32'(o_tx_valid), 32'd1);
        drain(v.stall_at, 5);
        check("idle_busy",  32'(o_busy), 32'd0);
        check("idle_rx_rdy", 32'(o_rx_ready), 32'd1);
        check("idle_tx_vld", 32'(o_tx_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{we:1'b1, adr:32'h0000_1000, wdat:32'hDEAD_BEEF, dly:3, ack:1'b1, err:1'b0,
                    rdat:32'h0, nresp:1, resp:32'h4B00_0000, stall_at:-1, garbage:1'b0};
        vecs[1] = '{we:1'b0, adr:32'h0000_1004, wdat:32'h0, dly:2, ack:1'b1, err:1'b0,
                    rdat:32'h1234_5678, nresp:4, resp:32'h1234_5678, stall_at:2, garbage:1'b1};
        vecs[2] = '{we:1'b1, adr:32'h0000_2000, wdat:32'h0BAD_F00D, dly:1, ack:1'b1, err:1'b1,
                    rdat:32'h0, nresp:1, resp:32'h4500_0000, stall_at:-1, garbage:1'b0};
        vecs[3] = '{we:1'b0, adr:32'h8000_0000, wdat:32'h0, dly:0, ack:1'b0, err:1'b1,
                    rdat:32'hFFFF_FFFF, nresp:1, resp:32'h4500_0000, stall_at:-1, garbage:1'b0};
        vecs[4] = '{we:1'b0, adr:32'h0000_0010, wdat:32'h0, dly:0, ack:1'b1, err:1'b0,
                    rdat:32'hA5A5_0F0F, nresp:4, resp:32'hA5A5_0F0F, stall_at:0, garbage:1'b0};
        vecs[5] = '{we:1'b1, adr:32'hFFFF_FFFC, wdat:32'h0000_0001, dly:1, ack:1'b1, err:1'b0,
                    rdat:32'h0, nresp:1, resp:32'h4B00_0000, stall_at:-1, garbage:1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rx_ready", 32'(o_rx_ready), 32'd0);
        check("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        check("rst_tx_byte",  32'(o_tx_byte),  32'd0);
        check("rst_cyc",      32'(o_wb_cyc),   32'd0);
        check("rst_stb",      32'(o_wb_stb),   32'd0);
        check("rst_we",       32'(o_wb_we),    32'd0);
        check("rst_sel",      32'(o_wb_sel),   32'd0);
        check("rst_adr",      o_wb_adr,        32'd0);
        check("rst_dat",      o_wb_dat,        32'd0);
        check("rst_busy",     32'(o_busy),     32'd0);
        i_rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Stray ack/err while idle must be ignored.
        $display("seq: ack/err in IDLE");
        i_wb_ack = 1'b1;
        i_wb_err = 1'b1;
        @(negedge clk);
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        @(negedge clk);
        check("stray_busy",     32'(o_busy),     32'd0);
        check("stray_tx_valid", 32'(o_tx_valid), 32'd0);
        check("stray_cyc",      32'(o_wb_cyc),   32'd0);

        // Reset while a cycle is outstanding.
        $display("seq: reset during Wishbone cycle");
        send_packet(1'b0, 32'h0000_3000, 32'h0);
        check("pre_rst_cyc", 32'(o_wb_cyc), 32'd1);
        i_rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cyc",  32'(o_wb_cyc),   32'd0);
        check("mid_rst_busy", 32'(o_busy),     32'd0);
        check("mid_rst_tx",   32'(o_tx_valid), 32'd0);
        i_rst = 1'b0;
        i_tx_ready = 1'b1;
        i_wb_ack = 1'b1;
        i_wb_dat = 32'hCAFE_CAFE;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_no_tx",  32'(o_tx_valid), 32'd0);
            check("post_rst_no_cyc", 32'(o_wb_cyc),   32'd0);
        end
        i_tx_ready = 1'b0;
        i_wb_ack = 1'b0;
        i_wb_dat = 32'h0;
        run_vec(6, vecs[0]);

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
        begin
            int n = 0;
            $display("seq: timeout, no ack");
            send_packet(1'b0, 32'h0000_4000, 32'h0);
            while (o_wb_cyc && n < 100) begin
                n++;
                @(negedge clk);
            end
            check("tmo_cycles", 32'(n), 32'd16);
            exp_q.push_back(8'h54);
            check("tmo_tx_valid", 32'(o_tx_valid), 32'd1);
            drain(-1, 0);
            check("tmo_idle", 32'(o_busy), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
